// File: rtl/param_mem_pkg.sv
// Shared state encoding, operation type and width helper for the multi-channel
// burst memory model.
package param_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Index width that never collapses to zero for single-entry structures.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_memory_mc_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found at or
// after the pointer, wrapping around. The pointer register lives in the parent.
module rr_arbiter
  import param_mem_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int CH_W = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o,
  output logic              any_o
);

  always_comb begin
    int  c;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(ptr_i) + k) % NUM_CH;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = CH_W'(c);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/param_memory_mc.sv
// Multi-channel cycle-approximate burst memory: one shared timing engine,
// round-robin arbitration and per-bank open-page latency modelling.
module param_memory_mc
  import param_mem_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int BURST_LEN  = 4,
  parameter int DELAY      = 50,
  parameter int PAGE_DELAY = 25,
  parameter int PAGE_BYTES = 256,
  parameter int NUM_BANKS  = 4,
  parameter int DEPTH      = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        mem_read,
  input  logic [NUM_CH-1:0]        mem_write,
  input  logic [NUM_CH*ADDR_W-1:0] mem_address,
  input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
  output logic [NUM_CH*DATA_W-1:0] mem_rdata,
  output logic [NUM_CH-1:0]        mem_resp,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count,
  output logic                     proto_err
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int LINE_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int BEAT_SH    = $clog2(BEAT_BYTES);
  localparam int PAGE_SH    = $clog2(PAGE_BYTES);
  localparam int PAGE_W     = ADDR_W - PAGE_SH;
  localparam int CH_W       = clog2_min1(NUM_CH);
  localparam int BANK_W     = clog2_min1(NUM_BANKS);
  localparam int CNT_W      = clog2_min1(DELAY);
  localparam int BEAT_W     = clog2_min1(BURST_LEN);
  localparam int IDX_W      = clog2_min1(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]               state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d, ptr_q, ptr_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  op_e                      op_q, op_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [NUM_CH-1:0]        resp_q, resp_d;
  logic [NUM_CH*DATA_W-1:0] rdata_q, rdata_d;
  logic [31:0]              hit_q, hit_d, miss_q, miss_d;
  logic                     err_q, err_d;
  logic [NUM_BANKS-1:0]     vld_q, vld_d;
  logic [PAGE_W-1:0]        pg_q [NUM_BANKS];
  logic [PAGE_W-1:0]        pg_d [NUM_BANKS];

  logic [NUM_CH-1:0] req_vec, gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any, g_rd, g_wr, alive, pg_hit;
  logic [ADDR_W-1:0] req_addr, aligned;
  logic [PAGE_W-1:0] gpage;
  logic [BANK_W-1:0] gbank;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a, input int b);
    logic [ADDR_W-1:0] w;
    w = (a >> BEAT_SH) + ADDR_W'(b);
    return IDX_W'(w % ADDR_W'(DEPTH));
  endfunction

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i (req_vec),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_vec  = mem_read | mem_write;
  assign g_rd     = |(mem_read & gnt);
  assign g_wr     = |(mem_write & gnt);
  assign req_addr = mem_address[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign aligned  = req_addr & ~ADDR_W'(LINE_BYTES - 1);
  assign gpage    = aligned[ADDR_W-1:PAGE_SH];
  assign gbank    = BANK_W'(gpage % PAGE_W'(NUM_BANKS));
  assign pg_hit   = vld_q[gbank] && (pg_q[gbank] == gpage);
  assign alive    = req_vec[ch_q];

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    err_d   = err_q;
    vld_d   = vld_q;
    pg_d    = pg_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d = ST_WAIT;
          ch_d    = gnt_idx;
          addr_d  = aligned;
          op_d    = (g_wr && !g_rd) ? OP_WRITE : OP_READ;
          if ((g_rd && g_wr) || (req_addr != aligned)) err_d = 1'b1;
          if (pg_hit) begin
            cnt_d = CNT_W'(PAGE_DELAY - 1);
            hit_d = (hit_q == '1) ? hit_q : hit_q + 32'd1;
          end else begin
            cnt_d        = CNT_W'(DELAY - 1);
            miss_d       = (miss_q == '1) ? miss_q : miss_q + 32'd1;
            vld_d[gbank] = 1'b1;
            pg_d[gbank]  = gpage;
          end
        end
      end
      ST_WAIT: begin
        if (!alive) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d      = ST_BURST;
          beat_d       = '0;
          resp_d[ch_q] = 1'b1;
          if (op_q == OP_READ)
            rdata_d[int'(ch_q)*DATA_W +: DATA_W] = mem[word_idx(addr_q, 0)];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BURST: begin
        if (!alive || beat_q == BEAT_W'(BURST_LEN - 1)) begin
          state_d = ST_DONE;
          resp_d  = '0;
          rdata_d = '0;
          if (!alive) err_d = 1'b1;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
          if (op_q == OP_READ)
            rdata_d[int'(ch_q)*DATA_W +: DATA_W] = mem[word_idx(addr_q, int'(beat_q) + 1)];
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = (int'(ch_q) == NUM_CH - 1) ? '0 : ch_q + CH_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      op_q    <= OP_READ;
      cnt_q   <= '0;
      beat_q  <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
    // Page tags need no reset: they are only consulted behind their valid bit.
    pg_q <= pg_d;
  end

  // Write beats commit at the end of their resp cycle; a dropped request or
  // reset on that edge suppresses the beat, earlier beats stay written.
  always_ff @(posedge clk) begin
    if (rst && state_q == ST_BURST && op_q == OP_WRITE && alive)
      mem[word_idx(addr_q, int'(beat_q))] <= mem_wdata[int'(ch_q)*DATA_W +: DATA_W];
  end

  assign mem_resp   = resp_q;
  assign mem_rdata  = rdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_param_memory_mc.sv
// Directed bench for param_memory_mc: table of single transfers with
// hand-computed latency, data and counters, plus reset/abort/round-robin cases.
module tb_param_memory_mc;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    mem_read, mem_write, mem_resp;
  logic [NCH*AW-1:0] mem_address;
  logic [NCH*DW-1:0] mem_wdata, mem_rdata;
  logic [31:0]       hit_count, miss_count;
  logic              proto_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_beats [4];

  typedef struct {
    int          ch;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [63:0] wbase;
    logic [63:0] ebase;
    int          lat;
    bit          chk_data;
    logic [31:0] hit;
    logic [31:0] miss;
    bit          err;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  param_memory_mc #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4), .DELAY(50),
    .PAGE_DELAY(25), .PAGE_BYTES(256), .NUM_BANKS(4), .DEPTH(4096)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .proto_err   (proto_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_stats(input string nm, input logic [31:0] h, input logic [31:0] m, input bit e);
    chk({nm, "_hit"}, 64'(hit_count), 64'(h));
    chk({nm, "_miss"}, 64'(miss_count), 64'(m));
    chk({nm, "_err"}, 64'(proto_err), 64'(e));
  endtask

  // One full transfer starting from IDLE; grant happens on the first posedge.
  task automatic do_xfer(input string nm, input int ch, input logic [31:0] addr,
                         input bit rd, input bit wr, input logic [63:0] wbase,
                         input int exp_lat, input bit chk_data);
    int n;
    bit got;
    bit oth_resp;
    int oth;
    oth = 1 - ch;
    oth_resp = 1'b0;
    @(negedge clk);
    mem_address[ch*AW +: AW] = addr;
    mem_wdata[ch*DW +: DW]   = wbase;
    mem_read[ch]  = rd;
    mem_write[ch] = wr;
    @(posedge clk);
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (mem_resp[oth]) oth_resp = 1'b1;
      if (mem_resp[ch]) got = 1'b1;
    end
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    if (got) begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin
          @(posedge clk); #1;
        end
        mem_wdata[ch*DW +: DW] = wbase + 64'(i);
        if (mem_resp[oth]) oth_resp = 1'b1;
        chk($sformatf("%s_resp%0d", nm, i), 64'(mem_resp[ch]), 64'd1);
        chk($sformatf("%s_idle_rdata%0d", nm, i), mem_rdata[oth*DW +: DW], 64'd0);
        if (chk_data)
          chk($sformatf("%s_rdata%0d", nm, i), mem_rdata[ch*DW +: DW], exp_beats[i]);
      end
      @(posedge clk); #1;
      chk({nm, "_done_resp"}, 64'(mem_resp), 64'd0);
    end
    chk({nm, "_other_resp"}, 64'(oth_resp), 64'd0);
    mem_read[ch]  = 1'b0;
    mem_write[ch] = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int          starts;
    int          order [4];
    bit          both_hi;
    bit          any_resp;
    logic [NCH-1:0] prev;

    rst = 1'b0;
    mem_read = '0;
    mem_write = '0;
    mem_address = '0;
    mem_wdata = '0;

    //    ch  addr    rd wr wbase       ebase     lat chk hit miss err
    vecs[0] = '{0, 32'h100, 0, 1, 64'h1000,   64'h0,    50, 0, 0, 1, 0};
    vecs[1] = '{0, 32'h100, 1, 0, 64'h0,      64'h1000, 25, 1, 1, 1, 0};
    vecs[2] = '{0, 32'h140, 0, 1, 64'h1400,   64'h0,    25, 0, 2, 1, 0};
    vecs[3] = '{0, 32'h140, 1, 0, 64'h0,      64'h1400, 25, 1, 3, 1, 0};
    vecs[4] = '{0, 32'h200, 0, 1, 64'hA0,     64'h0,    50, 0, 3, 2, 0};
    vecs[5] = '{1, 32'h200, 1, 0, 64'h0,      64'hA0,   25, 1, 4, 2, 0};
    vecs[6] = '{1, 32'h104, 1, 0, 64'h0,      64'h1000, 25, 1, 5, 2, 1};
    vecs[7] = '{0, 32'h140, 1, 1, 64'hDEAD00, 64'h1400, 25, 1, 6, 2, 1};
    vecs[8] = '{1, 32'h500, 1, 0, 64'h0,      64'h0,    50, 0, 6, 3, 1};
    vecs[9] = '{0, 32'h100, 1, 0, 64'h0,      64'h1000, 50, 1, 6, 4, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", 64'(mem_resp), 64'd0);
    chk("rst_rdata", mem_rdata[63:0] | mem_rdata[127:64], 64'd0);
    chk_stats("rst", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 4; i++) exp_beats[i] = vecs[v].ebase + 64'(i);
      do_xfer($sformatf("v%0d", v), vecs[v].ch, vecs[v].addr, vecs[v].rd, vecs[v].wr,
              vecs[v].wbase, vecs[v].lat, vecs[v].chk_data);
      chk_stats($sformatf("v%0d", v), vecs[v].hit, vecs[v].miss, vecs[v].err);
    end

    // Reset during beat 2 of a ch0 write to 0x100: beats 0,1 land, 2,3 keep old data.
    @(negedge clk);
    mem_address[0 +: AW] = 32'h100;
    mem_wdata[0 +: DW] = 64'h6000;
    mem_write[0] = 1'b1;
    @(posedge clk);
    starts = 0;
    for (int c = 0; c < 200 && starts < 3; c++) begin
      @(posedge clk); #1;
      if (mem_resp[0]) begin
        mem_wdata[0 +: DW] = 64'h6000 + 64'(starts);
        starts++;
      end
    end
    chk("rstmid_beats_seen", 64'(starts), 64'd3);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_resp", 64'(mem_resp), 64'd0);
    chk_stats("rstmid", 32'd0, 32'd0, 1'b0);
    mem_write[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_beats[0] = 64'h6000;
    exp_beats[1] = 64'h6001;
    exp_beats[2] = 64'h1002;
    exp_beats[3] = 64'h1003;
    do_xfer("rstmid_read", 0, 32'h100, 1, 0, 64'h0, 50, 1);
    chk_stats("rstmid_read", 32'd0, 32'd1, 1'b0);

    // Request dropped while waiting: transfer aborted, no beats, sticky error.
    @(negedge clk);
    mem_address[AW +: AW] = 32'h200;
    mem_read[1] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    mem_read[1] = 1'b0;
    any_resp = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (mem_resp != '0) any_resp = 1'b1;
    end
    chk("abort_resp", 64'(any_resp), 64'd0);
    chk_stats("abort", 32'd0, 32'd2, 1'b1);

    // Both channels held continuously from a fresh reset: strict alternation.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_address = {32'h200, 32'h100};
    mem_read = 2'b11;
    prev = '0;
    starts = 0;
    both_hi = 1'b0;
    for (int c = 0; c < 2000 && starts < 4; c++) begin
      @(posedge clk); #1;
      if (mem_resp == 2'b11) both_hi = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (mem_resp[k] && !prev[k] && starts < 4) begin
          order[starts] = k;
          starts++;
        end
      end
      prev = mem_resp;
    end
    chk("rr_starts", 64'(starts), 64'd4);
    chk("rr_exclusive", 64'(both_hi), 64'd0);
    for (int k = 0; k < 4 && k < starts; k++)
      chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(k % 2));
    chk_stats("rr", 32'd2, 32'd2, 1'b0);
    @(negedge clk);
    mem_read = '0;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
